// File: rtl/nibble_fifo_pkg.sv
// Shared sizing constants for the nibble FIFO slice.
package nibble_fifo_pkg;

  localparam int unsigned NF_WIDTH = 4;
  localparam int unsigned NF_DEPTH = 8;
  localparam int unsigned NF_AW    = $clog2(NF_DEPTH);

  // Occupancy at which the FIFO reports full.
  localparam int unsigned NF_FULL_COUNT = NF_DEPTH;

endpackage

// File: rtl/nibble_fifo_mem.sv
// DEPTH x WIDTH storage: one write port, one synchronous read port, no reset.
module nibble_fifo_mem #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register holds its value while no read is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/nibble_fifo.sv
// 8 x 4-bit FIFO with read-enable/valid handshake and sticky overflow/underflow flags.
module nibble_fifo
  import nibble_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = NF_WIDTH,
  parameter int unsigned DEPTH = NF_FULL_COUNT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wptr_d, wptr_q;
  logic [AW-1:0]    rptr_d, rptr_q;
  logic [CW-1:0]    count_d, count_q;
  logic             rd_valid_d, rd_valid_q;
  logic             overflow_d, overflow_q;
  logic             underflow_d, underflow_q;
  logic             rd_seen_d, rd_seen_q;
  logic             wr_acc, rd_acc;
  logic             full_c, empty_c;
  logic [WIDTH-1:0] mem_rdata;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);

  // Handshake acceptance, pointer/count/flag next-state.
  always_comb begin
    rd_acc      = rd_en && !empty_c;
    wr_acc      = wr_en && (!full_c || rd_acc);
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc;
    rd_seen_d   = rd_seen_q | rd_acc;
    overflow_d  = overflow_q | (wr_en && !wr_acc);
    underflow_d = underflow_q | (rd_en && empty_c);
    if (wr_acc) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_seen_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      rd_seen_q   <= rd_seen_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  nibble_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (mem_rdata)
  );

  // Storage has no reset, so rd_data reads as zero until the first read after reset.
  assign rd_data   = rd_seen_q ? mem_rdata : '0;
  assign rd_valid  = rd_valid_q;
  assign full      = full_c;
  assign empty     = empty_c;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
